clint_arbiter: RTL and testbench

CLINT_ARBITER -- requirements
Module: clint_arbiter

---
 rtl/clint_arb_pkg.sv | 26 ++
 rtl/clint_arb_rr.sv | 40 ++++
 rtl/clint_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_clint_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_arb_pkg.sv
// ============================================================================
//  Module   : clint_arb_pkg
//  Purpose  : Shared types and constants for the CLINT request arbiter.
//             Holds the arbiter FSM state encoding and the CLINT register
//             map base addresses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clint_arb_pkg;

   // Arbiter sequencing states (explicit 2-bit encoding)
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   // CLINT register map base addresses
   localparam int unsigned MSIP_BASE     = 0;
   localparam int unsigned MTIMECMP_BASE = 16384;
   localparam int unsigned MTIME_BASE    = 49144;

endpackage

`default_nettype wire

// File: rtl/clint_arb_rr.sv
// ============================================================================
//  Module   : clint_arb_rr
//  Purpose  : Combinational round-robin picker. Searches the pending vector
//             starting one position after the last grant, wrapping around.
//  Ports    : pend       - pending flag per requester
//             last_grant - index of the most recently completed requester
//             g          - selected requester index (valid when any=1)
//             any        - at least one requester is pending
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_arb_rr #(
   parameter int N_REQ = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_REQ-1:0] pend,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] g,
   output logic             any
);

   always_comb begin : p_pick
      int idx;
      g   = '0;
      any = 1'b0;
      idx = 0;
      // k = 1 first so the last winner has lowest priority
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant) + k) % N_REQ;
         if (!any && pend[idx]) begin
            any = 1'b1;
            g   = IDX_W'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/clint_arbiter.sv
// ============================================================================
//  Module   : clint_arbiter
//  Purpose  : Arbitrates N_REQ single-beat requesters onto one CLINT port.
//             Each requester owns a one-deep pending slot; slots are served
//             round-robin through an IDLE -> ISSUE -> WAIT sequence.
//  Ports    : clk, reset (sync, active-high)
//             req_valid/req_address/req_wdata/req_wstrb - packed requests
//             req_ready/req_rdata                       - completion
//             m_valid/m_address/m_wdata/m_wstrb         - CLINT request
//             m_rdata/m_ready                           - CLINT response
//             arb_err - watchdog timeout pulse (only with the macro below)
//  Config   : `define CLINT_ARB_TIMEOUT_EN enables the response watchdog
//             (TIMEOUT_CYC cycles counted from the ISSUE cycle).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_arbiter
   import clint_arb_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*ADDR_W-1:0]     req_address,
   input  logic [N_REQ*DATA_W-1:0]     req_wdata,
   input  logic [N_REQ*(DATA_W/8)-1:0] req_wstrb,
   output logic [N_REQ-1:0]            req_ready,
   output logic [DATA_W-1:0]           req_rdata,
   output logic                        m_valid,
   output logic [ADDR_W-1:0]           m_address,
   output logic [DATA_W-1:0]           m_wdata,
   output logic [DATA_W/8-1:0]         m_wstrb,
   input  logic [DATA_W-1:0]           m_rdata,
   input  logic                        m_ready
`ifdef CLINT_ARB_TIMEOUT_EN
   ,
   output logic                        arb_err
`endif
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("clint_arbiter: unsupported N_REQ or TIMEOUT_CYC");
   end

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [N_REQ-1:0]    r_pend;
   logic [ADDR_W-1:0]   r_addr [N_REQ];
   logic [DATA_W-1:0]   r_wdata[N_REQ];
   logic [STRB_W-1:0]   r_strb [N_REQ];
   logic [IDX_W-1:0]    r_grant;
   logic [IDX_W-1:0]    r_last;
   logic [IDX_W-1:0]    w_g;
   logic                w_any;
   logic                w_busy;
   logic                w_done;

   clint_arb_rr #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .pend       (r_pend),
      .last_grant (r_last),
      .g          (w_g),
      .any        (w_any)
   );

   assign w_busy = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

`ifdef CLINT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] r_tcnt;
   logic             w_tout;

   // Counter is 0 in the ISSUE cycle, so it reaches TIMEOUT_CYC exactly
   // TIMEOUT_CYC cycles after m_valid was driven.
   assign w_tout  = w_busy && !m_ready && (r_tcnt == CNT_W'(TIMEOUT_CYC));
   assign w_done  = !reset && w_busy && (m_ready || w_tout);
   assign arb_err = !reset && w_tout;

   always_ff @(posedge clk) begin
      if (reset || !w_busy || w_done) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end
`else
   // Reset gates completion so an in-flight transaction is silently dropped.
   assign w_done = !reset && w_busy && m_ready;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      m_valid     = 1'b0;
      m_address   = '0;
      m_wdata     = '0;
      m_wstrb     = '0;
      req_ready   = '0;
      req_rdata   = '0;

      case (r_state)
         ST_IDLE:  if (w_any)  w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = w_done ? ST_IDLE : ST_WAIT;
         ST_WAIT:  if (w_done) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase

      if (!reset && r_state == ST_ISSUE) begin
         m_valid   = 1'b1;
         m_address = r_addr[r_grant];
         m_wdata   = r_wdata[r_grant];
         m_wstrb   = r_strb[r_grant];
      end

      if (w_done) begin
         req_ready[r_grant] = 1'b1;
         // A watchdog completion has m_ready low and returns zero data.
         if (m_ready) begin
            req_rdata = m_rdata;
         end
      end
   end

   // Pending slots, grant and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend  <= '0;
         r_grant <= '0;
         r_last  <= IDX_W'(N_REQ - 1);
         for (int i = 0; i < N_REQ; i++) begin
            r_addr[i]  <= '0;
            r_wdata[i] <= '0;
            r_strb[i]  <= '0;
         end
      end else begin
         if (r_state == ST_IDLE && w_any) begin
            r_grant <= w_g;
         end
         if (w_done) begin
            r_last <= r_grant;
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (w_done && r_grant == IDX_W'(i)) begin
               r_pend[i] <= 1'b0;
            end
            // The slot being completed this cycle is free to reload, so a
            // request arriving in its own completion cycle is not lost.
            if (req_valid[i] &&
                (!r_pend[i] || (w_done && r_grant == IDX_W'(i)))) begin
               r_pend[i]  <= 1'b1;
               r_addr[i]  <= req_address[i*ADDR_W +: ADDR_W];
               r_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
               r_strb[i]  <= req_wstrb[i*STRB_W +: STRB_W];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_clint_arbiter.sv
// ============================================================================
//  Module   : tb_clint_arbiter
//  Purpose  : Self-checking bench for clint_arbiter (N_REQ=2 defaults).
//             Expected CLINT requests and requester completions are queued
//             when stimulus is driven and compared by a negedge monitor.
//  Config   : CLINT_ARB_TIMEOUT_EN adds the watchdog scenario.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_arbiter;

   localparam int N_REQ  = 2;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   logic                     clk;
   logic                     reset;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*ADDR_W-1:0]  req_address;
   logic [N_REQ*DATA_W-1:0]  req_wdata;
   logic [N_REQ*STRB_W-1:0]  req_wstrb;
   logic [N_REQ-1:0]         req_ready;
   logic [DATA_W-1:0]        req_rdata;
   logic                     m_valid;
   logic [ADDR_W-1:0]        m_address;
   logic [DATA_W-1:0]        m_wdata;
   logic [STRB_W-1:0]        m_wstrb;
   logic [DATA_W-1:0]        m_rdata;
   logic                     m_ready;
`ifdef CLINT_ARB_TIMEOUT_EN
   logic                     arb_err;
`endif

   clint_arbiter #(
      .N_REQ  (N_REQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .req_wstrb   (req_wstrb),
      .req_ready   (req_ready),
      .req_rdata   (req_rdata),
      .m_valid     (m_valid),
      .m_address   (m_address),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_rdata     (m_rdata),
      .m_ready     (m_ready)
`ifdef CLINT_ARB_TIMEOUT_EN
      ,
      .arb_err     (arb_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [STRB_W-1:0] s;
   } iss_t;

   typedef struct {
      logic [N_REQ-1:0]  rdy;
      logic [DATA_W-1:0] rd;
   } cpl_t;

   iss_t issq[$];
   cpl_t cplq[$];

   int n_cmp = 0;
   int n_mis = 0;
   bit mon_en = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; single-cycle pulses drop.
   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = '0;
      m_ready   = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic req(input int i, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
      req_valid[i] = 1'b1;
      req_address[i*ADDR_W +: ADDR_W] = a;
      req_wdata[i*DATA_W +: DATA_W]   = d;
      req_wstrb[i*STRB_W +: STRB_W]   = s;
   endtask

   task automatic push_iss(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [STRB_W-1:0] s);
      iss_t e;
      e.a = a; e.d = d; e.s = s;
      issq.push_back(e);
   endtask

   // Respond on the CLINT side this cycle and expect the matching completion.
   task automatic respond(input logic [N_REQ-1:0] who, input logic [DATA_W-1:0] rd);
      cpl_t e;
      m_ready = 1'b1;
      m_rdata = rd;
      e.rdy = who; e.rd = rd;
      cplq.push_back(e);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mon_en) begin
         iss_t ie;
         cpl_t ce;
         check_val("rdy_onehot", 64'($onehot0(req_ready)), 64'd1);
         if (!m_valid) begin
            check_val("m_idle_zero", 64'({m_address, m_wdata, m_wstrb}), 64'd0);
         end else if (issq.size() == 0) begin
            check_val("unexp_mvalid", 64'(m_valid), 64'd0);
         end else begin
            ie = issq.pop_front();
            check_val("m_address", 64'(m_address), 64'(ie.a));
            check_val("m_wdata",   64'(m_wdata),   64'(ie.d));
            check_val("m_wstrb",   64'(m_wstrb),   64'(ie.s));
         end
         if (req_ready == '0) begin
            check_val("rdata_zero", 64'(req_rdata), 64'd0);
         end else if (cplq.size() == 0) begin
            check_val("unexp_ready", 64'(req_ready), 64'd0);
         end else begin
            ce = cplq.pop_front();
            check_val("req_ready", 64'(req_ready), 64'(ce.rdy));
            check_val("req_rdata", 64'(req_rdata), 64'(ce.rd));
         end
      end
   end

   initial begin
      reset       = 1'b1;
      req_valid   = '0;
      req_address = '0;
      req_wdata   = '0;
      req_wstrb   = '0;
      m_rdata     = '0;
      m_ready     = 1'b0;

      // Reset state
      ticks(2);
      @(negedge clk);
      check_val("rst_mvalid", 64'(m_valid),   64'd0);
      check_val("rst_ready",  64'(req_ready), 64'd0);
      check_val("rst_rdata",  64'(req_rdata), 64'd0);
      check_val("rst_maddr",  64'(m_address), 64'd0);
      check_val("rst_mwstrb", 64'(m_wstrb),   64'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Single request: latency n+2, completion 3 cycles after issue
      tick();
      req(0, 16'h4000, 32'd20, 4'hF);
      push_iss(16'h4000, 32'd20, 4'hF);
      tick();
      @(negedge clk) check_val("lat_n1", 64'(m_valid), 64'd0);
      tick();
      @(negedge clk) check_val("lat_n2", 64'(m_valid), 64'd1);
      ticks(3);
      respond(2'b01, 32'hDEAD_BEEF);
      @(negedge clk) check_val("single_rdy", 64'(req_ready), 64'h1);
      tick();
      @(negedge clk) check_val("single_1pulse", 64'(req_ready), 64'h0);

      // Contention after reset: req0 first, then req1
      reset_dut();
      req(0, 16'h0000, 32'h1, 4'hF);
      req(1, 16'h4008, 32'h55, 4'h3);
      push_iss(16'h0000, 32'h1, 4'hF);
      push_iss(16'h4008, 32'h55, 4'h3);
      ticks(2);
      @(negedge clk) check_val("cont_a_iss", 64'(m_valid), 64'd1);
      tick();
      respond(2'b01, 32'hA0);
      ticks(2);
      respond(2'b10, 32'hA1);
      @(negedge clk) check_val("cont_b_iss", 64'(m_valid), 64'd1);
      // Second simultaneous pair: last_grant=1 so req0 wins again
      tick();
      req(0, 16'hBFF8, 32'h2, 4'h1);
      req(1, 16'h4010, 32'h66, 4'hC);
      push_iss(16'hBFF8, 32'h2, 4'h1);
      push_iss(16'h4010, 32'h66, 4'hC);
      ticks(2);
      respond(2'b01, 32'hB0);
      @(negedge clk) check_val("cont_c_iss", 64'(m_valid), 64'd1);
      ticks(2);
      respond(2'b10, 32'hB1);
      @(negedge clk) check_val("cont_d_iss", 64'(m_valid), 64'd1);

      // Re-request in own completion cycle
      tick();
      req(0, 16'h0004, 32'h11, 4'hF);
      push_iss(16'h0004, 32'h11, 4'hF);
      ticks(3);
      respond(2'b01, 32'hC0);
      req(0, 16'h0008, 32'h22, 4'h0);
      push_iss(16'h0008, 32'h22, 4'h0);
      tick();
      @(negedge clk) check_val("rereq_idle", 64'(m_valid), 64'd0);
      tick();
      @(negedge clk) check_val("rereq_iss", 64'(m_valid), 64'd1);
      respond(2'b01, 32'hC1);

      // Duplicate pulses while pending: one transaction only
      tick();
      req(1, 16'h4020, 32'h77, 4'hF);
      push_iss(16'h4020, 32'h77, 4'hF);
      tick();
      req(1, 16'h4024, 32'h88, 4'hF);
      tick();
      req(1, 16'h4028, 32'h99, 4'hF);
      @(negedge clk) check_val("dup_iss", 64'(m_valid), 64'd1);
      ticks(2);
      respond(2'b10, 32'hD0);
      ticks(6);
      check_val("dup_issq_empty", 64'(issq.size()), 64'd0);

      // Reset during WAIT discards the transaction
      req(0, 16'h4030, 32'h5A, 4'hF);
      push_iss(16'h4030, 32'h5A, 4'hF);
      ticks(2);
      @(negedge clk) check_val("rstw_iss", 64'(m_valid), 64'd1);
      tick();
      reset = 1'b1;
      @(negedge clk) check_val("rstw_rdy", 64'(req_ready), 64'd0);
      tick();
      reset   = 1'b0;
      m_ready = 1'b1;
      m_rdata = 32'hE0;
      @(negedge clk) begin
         check_val("rstw_mvalid", 64'(m_valid),   64'd0);
         check_val("rstw_idle_rdy", 64'(req_ready), 64'd0);
      end
      ticks(3);
      @(negedge clk) check_val("rstw_pend", 64'(m_valid), 64'd0);
      m_rdata = '0;

`ifdef CLINT_ARB_TIMEOUT_EN
      // Watchdog: no m_ready, completion TIMEOUT_CYC cycles after issue
      tick();
      m_rdata = 32'hFFFF_FFFF;
      req(0, 16'h4040, 32'h1234, 4'hF);
      push_iss(16'h4040, 32'h1234, 4'hF);
      ticks(2);
      @(negedge clk) check_val("tout_iss", 64'(m_valid), 64'd1);
      ticks(63);
      @(negedge clk) check_val("tout_early", 64'(arb_err), 64'd0);
      begin
         cpl_t e;
         e.rdy = 2'b01; e.rd = '0;
         cplq.push_back(e);
      end
      tick();
      @(negedge clk) check_val("tout_err", 64'(arb_err), 64'd1);
      tick();
      @(negedge clk) check_val("tout_err_1cyc", 64'(arb_err), 64'd0);
      m_rdata = '0;
`endif

      ticks(2);
      check_val("issq_empty", 64'(issq.size()), 64'd0);
      check_val("cplq_empty", 64'(cplq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
